// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder (MSB first) on the CPU peripheral register bus.
// SCLK/MOSI/CS_N are oversampled in the raw_clk domain; TX and RX bytes go through
// small FIFOs that the CPU accesses through four registers.

// Byte FIFO used for both directions. A pop and a push in the same cycle
// both take effect, so a full FIFO can accept a push when it is also popped.
module spi_target_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush overrides any concurrent push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module spi_target #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        write_enable,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_d, cs_d;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic       armed, start;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [6:0] tx_sh, rx_sh;
  logic [7:0] fill, load_byte;
  logic       tx_load;

  logic       wr, rd;
  logic       tx_push, tx_pop, rx_push, rx_pop, flush, clr_flags;
  logic [7:0] tx_head, rx_head, rx_data;
  logic [AW:0] tx_count, rx_count;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_overflow, rx_overrun, tx_underrun;
  logic       unused_data_hi;

  assign unused_data_hi = ^data_in[15:8];

  // Two-flop synchronizers plus one delay stage for edge detection. CS resets
  // low so that a master holding CS low through reset produces no edges.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign start     = cs_fall && armed;

  // Next TX byte is needed at transaction start and on the fall after a byte.
  assign tx_load   = start ||
                     (spi_miso_oe && !cs_rise && sclk_fall && bit_cnt == 3'd0 && byte_done);
  assign load_byte = tx_empty ? fill : tx_head;
  assign tx_pop    = tx_load && !tx_empty;

  assign rx_data   = {rx_sh, mosi_sync[1]};
  assign rx_push   = spi_miso_oe && !cs_rise && sclk_rise && bit_cnt == 3'd7;

  // Arm once CS has been seen high, so a select held across reset is ignored.
  always_ff @(posedge raw_clk) begin
    if (reset)             armed <= 1'b0;
    else if (cs_sync[1])   armed <= 1'b1;
  end

  // SPI shift engine: abort on CS rise, load on start, shift on SCLK edges.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      spi_miso_oe <= 1'b0;
      spi_miso    <= 1'b0;
      bit_cnt     <= 3'd0;
      byte_done   <= 1'b0;
      tx_sh       <= 7'd0;
      rx_sh       <= 7'd0;
    end else if (cs_rise) begin
      spi_miso_oe <= 1'b0;
      spi_miso    <= 1'b0;
      bit_cnt     <= 3'd0;
      byte_done   <= 1'b0;
    end else if (start) begin
      spi_miso_oe <= 1'b1;
      bit_cnt     <= 3'd0;
      byte_done   <= 1'b0;
      tx_sh       <= load_byte[6:0];
      spi_miso    <= load_byte[7];
    end else if (spi_miso_oe) begin
      if (sclk_rise) begin
        rx_sh     <= {rx_sh[5:0], mosi_sync[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end else if (sclk_fall) begin
        if (bit_cnt != 3'd0) begin
          spi_miso <= tx_sh[6];
          tx_sh    <= {tx_sh[5:0], 1'b0};
        end else if (byte_done) begin
          spi_miso  <= load_byte[7];
          tx_sh     <= load_byte[6:0];
          byte_done <= 1'b0;
        end
      end
    end
  end

  assign wr        = enable && write_enable;
  assign rd        = enable && !write_enable;
  assign tx_push   = wr && address == 2'd0;
  assign rx_pop    = wr && address == 2'd1 && data_in[0];
  assign clr_flags = wr && address == 2'd1 && data_in[1];
  assign flush     = wr && address == 2'd1 && data_in[2];

  spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(raw_clk), .reset(reset), .push(tx_push), .push_data(data_in[7:0]),
    .pop(tx_pop), .flush(flush), .head(tx_head), .count(tx_count),
    .full(tx_full), .empty(tx_empty)
  );

  spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(raw_clk), .reset(reset), .push(rx_push), .push_data(rx_data),
    .pop(rx_pop), .flush(flush), .head(rx_head), .count(rx_count),
    .full(rx_full), .empty(rx_empty)
  );

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_overflow <= (tx_overflow && !clr_flags) || (tx_push && tx_full && !tx_pop && !flush);
      rx_overrun  <= (rx_overrun && !clr_flags)  || (rx_push && rx_full && !rx_pop && !flush);
      tx_underrun <= (tx_underrun && !clr_flags) || (tx_load && tx_empty);
    end
  end

  // Fill byte sent whenever the TX FIFO has nothing to offer.
  always_ff @(posedge raw_clk) begin
    if (reset)                        fill <= 8'hFF;
    else if (wr && address == 2'd3)   fill <= data_in[7:0];
  end

  // Registered read port; holds its value between read strobes.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      data_out <= 16'h0000;
    end else if (rd) begin
      case (address)
        2'd0:    data_out <= rx_empty ? 16'h0000 : {8'h00, rx_head};
        2'd1:    data_out <= {8'h00, tx_overflow, rx_overrun, tx_underrun, spi_miso_oe,
                              tx_full, tx_empty, rx_full, rx_empty};
        2'd2:    data_out <= {8'(rx_count), 8'(tx_count)};
        default: data_out <= {8'h00, fill};
      endcase
    end
  end
endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: stimulus pushes expected register reads and
// MISO bytes into queues; monitors pop and compare when the DUT produces them.
module tb_spi_target;
  logic        raw_clk = 1'b0;
  logic        reset, enable, write_enable;
  logic [1:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        spi_sclk, spi_mosi, spi_cs_n;
  logic        spi_miso, spi_miso_oe;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_rd[$];
  string       rd_name[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  got_byte;
  logic        rd_d = 1'b0;
  event        miso_ev;

  spi_target #(.FIFO_DEPTH(4)) dut (
    .raw_clk(raw_clk), .reset(reset), .enable(enable), .address(address),
    .data_in(data_in), .data_out(data_out), .write_enable(write_enable),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 raw_clk = ~raw_clk;

  function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // A read strobe seen at a posedge means data_out is valid afterwards.
  always @(posedge raw_clk) rd_d <= enable && !write_enable;

  // Register-read monitor.
  always @(negedge raw_clk) begin
    if (rd_d) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected none", data_out);
      end else begin
        check(rd_name.pop_front(), data_out, exp_rd.pop_front());
      end
    end
  end

  // MISO byte monitor.
  always @(miso_ev) begin
    if (exp_miso.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_miso: got %h expected none", got_byte);
    end else begin
      check("miso_byte", {8'h00, got_byte}, {8'h00, exp_miso.pop_front()});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge raw_clk);
    enable = 1'b1; write_enable = 1'b1; address = a; data_in = d;
    @(negedge raw_clk);
    enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, input logic [15:0] e, input string nm);
    exp_rd.push_back(e);
    rd_name.push_back(nm);
    @(negedge raw_clk);
    enable = 1'b1; write_enable = 1'b0; address = a;
    @(negedge raw_clk);
    enable = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  // Raise CS (possibly while SCLK is still high) and then return SCLK low.
  task automatic cs_high();
    spi_cs_n = 1'b1;
    tick(6);
    spi_sclk = 1'b0;
    tick(8);
  endtask

  // One master byte: MISO sampled just before each rise. hold_last leaves SCLK
  // high after the final rise; pop_last issues a CPU RX pop exactly on the
  // cycle the DUT pushes the received byte.
  task automatic spi_byte(input logic [7:0] mo, input logic [7:0] exp, input bit chk,
                          input int nbits, input bit hold_last, input bit pop_last);
    logic [7:0] got = 8'h00;
    if (chk) exp_miso.push_back(exp);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      tick(6);
      got[7-i] = spi_miso;
      spi_sclk = 1'b1;
      if (pop_last && i == 7) begin
        tick(2);
        enable = 1'b1; write_enable = 1'b1; address = 2'd1; data_in = 16'h0001;
        tick(1);
        enable = 1'b0; write_enable = 1'b0;
        tick(3);
      end else begin
        tick(6);
      end
      if (!(hold_last && i == nbits - 1)) spi_sclk = 1'b0;
    end
    if (chk) begin
      got_byte = got;
      -> miso_ev;
    end
  endtask

  initial begin
    enable = 1'b0; write_enable = 1'b0; address = 2'd0; data_in = 16'h0000;
    spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(4);

    // Reset state
    check("rst_oe", {15'b0, spi_miso_oe}, 16'h0000);
    check("rst_miso", {15'b0, spi_miso}, 16'h0000);
    reg_rd(2'd1, 16'h0005, "rst_status");
    reg_rd(2'd3, 16'h00FF, "rst_fill");
    reg_rd(2'd2, 16'h0000, "rst_counts");
    reg_rd(2'd0, 16'h0000, "rst_rx_head");

    // Basic exchange: TX A5, master sends 3C
    reg_wr(2'd0, 16'h00A5);
    reg_rd(2'd1, 16'h0001, "tx_loaded");
    reg_rd(2'd2, 16'h0001, "tx_count1");
    cs_low();
    spi_byte(8'h3C, 8'hA5, 1'b1, 8, 1'b1, 1'b0);
    cs_high();
    reg_rd(2'd0, 16'h003C, "rx_3c");
    reg_rd(2'd1, 16'h0004, "after_a5");
    reg_wr(2'd1, 16'h0001);
    reg_rd(2'd2, 16'h0000, "popped");

    // Underrun: two bytes with TX empty, then clear and flush
    cs_low();
    spi_byte(8'h11, 8'hFF, 1'b1, 8, 1'b0, 1'b0);
    spi_byte(8'h22, 8'hFF, 1'b1, 8, 1'b1, 1'b0);
    cs_high();
    reg_rd(2'd2, 16'h0200, "rx_two");
    reg_rd(2'd1, 16'h0024, "underrun");
    reg_wr(2'd1, 16'h0002);
    reg_rd(2'd1, 16'h0004, "underrun_clr");
    reg_wr(2'd1, 16'h0004);
    reg_rd(2'd1, 16'h0005, "flushed");

    // Programmable fill byte
    reg_wr(2'd3, 16'h005A);
    reg_rd(2'd3, 16'h005A, "fill_rd");
    cs_low();
    spi_byte(8'h33, 8'h5A, 1'b1, 8, 1'b1, 1'b0);
    cs_high();
    reg_rd(2'd0, 16'h0033, "rx_33");
    reg_wr(2'd1, 16'h0006);
    reg_wr(2'd3, 16'h00FF);
    reg_rd(2'd1, 16'h0005, "clean1");

    // RX overrun: five bytes into a 4-deep FIFO
    cs_low();
    for (int b = 1; b <= 5; b++)
      spi_byte(8'(b), 8'hFF, 1'b1, 8, b == 5, 1'b0);
    cs_high();
    reg_rd(2'd2, 16'h0400, "rx_cnt4");
    reg_rd(2'd0, 16'h0001, "rx_head01");
    reg_rd(2'd1, 16'h0066, "overrun");
    reg_wr(2'd1, 16'h0001);
    reg_rd(2'd0, 16'h0002, "rx_02");
    reg_wr(2'd1, 16'h0001);
    reg_rd(2'd0, 16'h0003, "rx_03");
    reg_wr(2'd1, 16'h0001);
    reg_rd(2'd0, 16'h0004, "rx_04");
    reg_wr(2'd1, 16'h0001);
    reg_rd(2'd0, 16'h0000, "rx_05_lost");
    reg_wr(2'd1, 16'h0006);
    reg_rd(2'd1, 16'h0005, "clean2");

    // Abort after 5 rises; preloaded TX byte is consumed and lost
    reg_wr(2'd0, 16'h00C3);
    cs_low();
    spi_byte(8'hF0, 8'h00, 1'b0, 5, 1'b0, 1'b0);
    cs_high();
    check("abort_oe", {15'b0, spi_miso_oe}, 16'h0000);
    check("abort_miso", {15'b0, spi_miso}, 16'h0000);
    reg_rd(2'd2, 16'h0000, "abort_cnt");
    reg_rd(2'd1, 16'h0005, "abort_flags");
    cs_low();
    spi_byte(8'h81, 8'hFF, 1'b1, 8, 1'b1, 1'b0);
    cs_high();
    reg_rd(2'd0, 16'h0081, "rx_81");
    reg_wr(2'd1, 16'h0006);

    // CPU pop concurrent with SPI push into a full RX FIFO
    cs_low();
    for (int b = 0; b < 4; b++)
      spi_byte(8'(8'h10 + b), 8'hFF, 1'b1, 8, 1'b0, 1'b0);
    spi_byte(8'h14, 8'hFF, 1'b1, 8, 1'b1, 1'b1);
    cs_high();
    reg_rd(2'd2, 16'h0400, "simul_cnt");
    reg_rd(2'd1, 16'h0026, "simul_flags");
    reg_rd(2'd0, 16'h0011, "simul_head");
    reg_wr(2'd1, 16'h0001);
    reg_wr(2'd1, 16'h0001);
    reg_wr(2'd1, 16'h0001);
    reg_rd(2'd0, 16'h0014, "simul_tail");
    reg_wr(2'd1, 16'h0006);

    // Reset with CS held low: ignored until CS has gone high
    spi_cs_n = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    spi_byte(8'h55, 8'h00, 1'b0, 8, 1'b0, 1'b0);
    check("unarmed_oe", {15'b0, spi_miso_oe}, 16'h0000);
    reg_rd(2'd2, 16'h0000, "unarmed_cnt");
    reg_rd(2'd1, 16'h0005, "unarmed_status");
    reg_wr(2'd0, 16'h0099);
    cs_high();
    cs_low();
    spi_byte(8'h77, 8'h99, 1'b1, 8, 1'b1, 1'b0);
    cs_high();
    reg_rd(2'd0, 16'h0077, "rearmed_rx");

    tick(4);
    check("rd_queue_drained", 16'(exp_rd.size()), 16'h0000);
    check("miso_queue_drained", 16'(exp_miso.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
